// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared CPU types, default widths and request opcodes
package mem_responder_pkg;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_ERR = 2'b11;
   typedef enum logic [2:0] {IDLE, WAIT, RESP_RD, RESP_WR, ERR} state_t;
   function automatic logic [1:0] op_of(input logic rd, input logic wr);
      return {wr, rd};
   endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side request/response bus of the memory responder
interface mem_responder_if import mem_responder_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0] addr;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              wack;
   logic              ready;
   logic              err;
   modport master (output addr, rd, wr, wdata, input rdata, rvalid, wack, ready, err);
   modport slave  (input addr, rd, wr, wdata, output rdata, rvalid, wack, ready, err);
endinterface

// File: rtl/mem_responder_array.sv
// mem_array: unreset storage with one write port and one registered read port
module mem_array #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge rst)
      if (!rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated single-request memory responder FSM
module mem_responder import mem_responder_pkg::*; #(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = 1
) (
   input logic           clk,
   input logic           rst,
   mem_responder_if.slave bus
);
   localparam state_t FIRST_RD = WAIT_CYCLES == 0 ? RESP_RD : WAIT;
   localparam state_t FIRST_WR = WAIT_CYCLES == 0 ? RESP_WR : WAIT;
   state_t            state, nxt;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] addr_q, a;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic [1:0]        op;
   assign op = op_of(bus.rd, bus.wr);
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE: case (op)
            OP_NOP: nxt = IDLE;
            OP_RD:  nxt = FIRST_RD;
            OP_WR:  nxt = FIRST_WR;
            OP_ERR: nxt = ERR;
         endcase
         WAIT:    nxt = cnt == 3'd1 ? (wr_q ? RESP_WR : RESP_RD) : WAIT;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && (op == OP_RD || op == OP_WR)) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            wr_q    <= op == OP_WR;
            cnt     <= 3'(WAIT_CYCLES);
         end else if (state == WAIT) cnt <= cnt - 3'd1;
      end
   // zero-wait accesses hit the array on the accept edge, before the latches fill
   assign a = state == IDLE ? bus.addr : addr_q;
   assign bus.ready  = state == IDLE;
   assign bus.rvalid = state == RESP_RD;
   assign bus.wack   = state == RESP_WR;
   assign bus.err    = state == ERR;
   mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (rst && nxt == RESP_WR),
      .re    (rst && nxt == RESP_RD),
      .waddr (a),
      .raddr (a),
      .wdata (state == IDLE ? bus.wdata : wdata_q),
      .rdata (bus.rdata)
   );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks on three responders with 1, 0 and 3 wait states
module tb_mem_responder;
   logic       clk = 0, rst = 1;
   logic       rd = 0, wr = 0;
   logic [4:0] addr = 0;
   logic [7:0] wdata = 0;
   int         sel = 0;
   int         n_chk = 0, n_pass = 0;
   int         lat, issued, got, last, cyc, hits;
   logic [7:0] q;
   logic [2:0] k;
   always #5 clk = ~clk;
   mem_responder_if #(.ADDR_W(5), .DATA_W(8)) b0 (), b1 (), b2 ();
   assign b0.rd = rd && sel == 0;
   assign b0.wr = wr && sel == 0;
   assign b0.addr = addr;
   assign b0.wdata = wdata;
   assign b1.rd = rd && sel == 1;
   assign b1.wr = wr && sel == 1;
   assign b1.addr = addr;
   assign b1.wdata = wdata;
   assign b2.rd = rd && sel == 2;
   assign b2.wr = wr && sel == 2;
   assign b2.addr = addr;
   assign b2.wdata = wdata;
   mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(1)) d0 (.clk(clk), .rst(rst), .bus(b0));
   mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) d1 (.clk(clk), .rst(rst), .bus(b1));
   mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(3)) d2 (.clk(clk), .rst(rst), .bus(b2));
   logic       ready_s, rvalid_s, wack_s, err_s;
   logic [7:0] rdata_s;
   assign ready_s  = sel == 0 ? b0.ready  : sel == 1 ? b1.ready  : b2.ready;
   assign rvalid_s = sel == 0 ? b0.rvalid : sel == 1 ? b1.rvalid : b2.rvalid;
   assign wack_s   = sel == 0 ? b0.wack   : sel == 1 ? b1.wack   : b2.wack;
   assign err_s    = sel == 0 ? b0.err    : sel == 1 ? b1.err    : b2.err;
   assign rdata_s  = sel == 0 ? b0.rdata  : sel == 1 ? b1.rdata  : b2.rdata;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_chk++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37 + 11);
   endfunction

   task automatic wait_ready;
      int n = 0;
      while (!ready_s && n < 50) begin
         tick;
         n++;
      end
      if (n >= 50) check("ready_timeout", 0, 1);
   endtask

   // lat counts edges from the accept edge (inclusive) to the visible strobe
   task automatic access(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d,
                         output int l, output logic [7:0] data, output logic [2:0] kind);
      wait_ready;
      rd = r;
      wr = w;
      addr = a;
      wdata = d;
      tick;
      rd = 0;
      wr = 0;
      l = 1;
      while (!(rvalid_s || wack_s || err_s) && l < 20) begin
         tick;
         l++;
      end
      data = rdata_s;
      kind = {rvalid_s, wack_s, err_s};
   endtask

   initial begin
      #2 rst = 0;
      tick;
      tick;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset_out%0d", s), {ready_s, rvalid_s, wack_s, err_s, rdata_s}, {4'b1000, 8'h00});
      end
      rst = 1;
      sel = 0;
      tick;
      access(0, 1, 5'h03, 8'h5A, lat, q, k);
      check("w1_wr_lat", lat, 2);
      check("w1_wr_kind", k, 3'b010);
      access(1, 0, 5'h03, 8'h00, lat, q, k);
      check("w1_rd_lat", lat, 2);
      check("w1_rd_kind", k, 3'b100);
      check("w1_rd_data", q, 8'h5A);
      for (int i = 0; i < 32; i++) access(0, 1, 5'(i), pat(i), lat, q, k);
      access(1, 1, 5'h07, 8'hEE, lat, q, k);
      check("err_lat", lat, 1);
      check("err_kind", k, 3'b001);
      tick;
      check("err_drop", {rvalid_s, wack_s, err_s}, 3'b000);
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         hits += int'(rvalid_s) + int'(wack_s) + int'(err_s);
      end
      check("err_quiet", hits, 0);
      access(1, 0, 5'h07, 8'h00, lat, q, k);
      check("err_mem_kept", q, pat(7));
      wait_ready;
      rd = 1;
      addr = 5'h05;
      tick;
      rd = 0;
      check("ign_busy", ready_s, 0);
      rd = 1;
      addr = 5'h10;
      tick;
      rd = 0;
      check("ign_resp", {rvalid_s, rdata_s}, {1'b1, pat(5)});
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         hits += int'(rvalid_s);
      end
      check("ign_no_extra", hits, 0);
      issued = 0;
      got = 0;
      last = -1;
      cyc = 0;
      while (got < 32 && cyc < 200) begin
         if (ready_s) begin
            if (issued < 32) begin
               addr = 5'(issued);
               rd = 1;
               issued++;
            end else rd = 0;
         end
         tick;
         cyc++;
         if (rvalid_s) begin
            check($sformatf("stream_data%0d", got), rdata_s, pat(got));
            if (last >= 0) check($sformatf("stream_period%0d", got), cyc - last, 3);
            last = cyc;
            got++;
         end
      end
      rd = 0;
      check("stream_count", got, 32);
      sel = 1;
      tick;
      tick;
      access(0, 1, 5'h1F, 8'hC3, lat, q, k);
      check("w0_wr_lat", lat, 1);
      access(1, 0, 5'h1F, 8'h00, lat, q, k);
      check("w0_rd_lat", lat, 1);
      check("w0_rd_data", q, 8'hC3);
      check("w0_busy", ready_s, 0);
      tick;
      check("w0_ready_back", ready_s, 1);
      sel = 2;
      access(0, 1, 5'h00, 8'h11, lat, q, k);
      check("w3_wr_lat", lat, 4);
      access(1, 0, 5'h00, 8'h00, lat, q, k);
      check("w3_rd_lat", lat, 4);
      check("w3_rd_data", q, 8'h11);
      wait_ready;
      wr = 1;
      addr = 5'h00;
      wdata = 8'hFF;
      tick;
      wr = 0;
      tick;
      check("w3_in_wait", ready_s, 0);
      rst = 0;
      #1;
      check("w3_rst_out", {ready_s, rvalid_s, wack_s, err_s, rdata_s}, {4'b1000, 8'h00});
      tick;
      tick;
      rst = 1;
      tick;
      check("w3_ready_after", ready_s, 1);
      access(1, 0, 5'h00, 8'h00, lat, q, k);
      check("w3_abort_kept", q, 8'h11);
      sel = 0;
      access(1, 0, 5'h1F, 8'h00, lat, q, k);
      check("w1_mem_survives_rst", q, pat(31));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
